// File: rtl/cfu_cmd_sequencer_if.sv
// cfu_cmd_sequencer_if
//   CFU command/response handshake bundle.
//   master : the command initiator (drives cmd_*, rsp_ready)
//   slave  : the CFU (drives cmd_ready, rsp_valid, rsp_payload_outputs_0)
interface cfu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  cmd_ready,
    input  rsp_valid, rsp_payload_outputs_0,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output cmd_ready,
    output rsp_valid, rsp_payload_outputs_0,
    input  rsp_ready
  );
endinterface

// File: rtl/cfu_cmd_sequencer.sv
// cfu_cmd_sequencer
//   Runs a job of job_count CFU commands sharing one function_id. Operand
//   pairs come from an internal FIFO filled by the op_* push port; at most
//   one command is outstanding, and each CFU response is forwarded on the
//   res_* stream with res_last marking the final one of the job.
// Ports
//   clk, reset         clock, synchronous active-high reset
//   job_*              job request (accepted only in IDLE)
//   op_*               operand push port, op_ready = FIFO not full
//   cfu                CFU command/response bundle (master side)
//   res_*              result stream, held until res_ready
//   busy, done         not-IDLE flag, one-cycle completion pulse
module cfu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [9:0]         job_function_id,
  input  logic [COUNT_W-1:0] job_count,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [31:0]        op_input_0,
  input  logic [31:0]        op_input_1,
  cfu_cmd_sequencer_if.master cfu,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               res_last,
  output logic               busy,
  output logic               done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in0;
  } op_pair_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t             state;
  op_pair_t           mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        occ;
  logic [9:0]         fid_q;
  logic [COUNT_W-1:0] remaining;
  logic               push, pop, cmd_fire, rsp_fire;
  op_pair_t           head;

  // ---------------- operand FIFO (state independent) ----------------
  assign op_ready = (occ != OCC_FULL);
  assign push     = op_valid & op_ready;
  assign pop      = cmd_fire;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{in1: op_input_1, in0: op_input_0};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---------------- CFU side ----------------
  assign cfu.cmd_valid               = (state == ISSUE) && (occ != '0);
  assign cfu.cmd_payload_function_id = fid_q;
  assign cfu.cmd_payload_inputs_0    = head.in0;
  assign cfu.cmd_payload_inputs_1    = head.in1;

  // IDLE swallows stale responses left over from a reset mid-job.
  always_comb begin
    cfu.rsp_ready = 1'b0;
    case (state)
      IDLE:     cfu.rsp_ready = 1'b1;
      WAIT_RSP: cfu.rsp_ready = ~res_valid | res_ready;
      default:  cfu.rsp_ready = 1'b0;
    endcase
  end

  assign cmd_fire  = cfu.cmd_valid & cfu.cmd_ready;
  assign rsp_fire  = (state == WAIT_RSP) & cfu.rsp_valid & cfu.rsp_ready;
  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fid_q     <= '0;
      remaining <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A capture below in the same cycle overrides this drop (back-to-back).
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid) begin
            fid_q     <= job_function_id;
            remaining <= job_count;
            if (job_count == '0) done  <= 1'b1;
            else                 state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_fire) begin
            if (remaining != '0) remaining <= remaining - COUNT_W'(1);
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_fire) begin
            res_valid <= 1'b1;
            res_data  <= cfu.rsp_payload_outputs_0;
            res_last  <= (remaining == '0);
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// tb_cfu_cmd_sequencer
//   Directed bench: inputs change 1 time unit after posedge, outputs are
//   sampled on negedge. A CFU model adds inputs_0+inputs_1 after a
//   programmable delay. Operand pushes feed a model queue; each observed
//   command fire pushes its expected result to a scoreboard that is popped
//   on every res_valid & res_ready.
module tb_cfu_cmd_sequencer;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               job_valid, job_ready;
  logic [9:0]         job_function_id;
  logic [COUNT_W-1:0] job_count;
  logic               op_valid, op_ready;
  logic [31:0]        op_input_0, op_input_1;
  logic               res_valid, res_ready, res_last, busy, done;
  logic [31:0]        res_data;

  cfu_cmd_sequencer_if cf();

  cfu_cmd_sequencer #(.FIFO_DEPTH(4), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_function_id(job_function_id), .job_count(job_count),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_input_0(op_input_0), .op_input_1(op_input_1),
    .cfu(cf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- models / scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
  } res_t;

  logic [63:0] op_q[$];
  res_t        exp_q[$];
  logic [9:0]  cur_fid = '0;
  int          cmd_left = 0;
  int          done_cnt = 0;
  int          rsp_delay = 0;
  logic [63:0] mp;
  res_t        er;

  always @(negedge clk) begin
    if (!reset) begin
      if (cf.cmd_valid && cf.cmd_ready) begin
        chk("cmd_in_job", (cmd_left > 0) && (op_q.size() > 0), 1'b1);
        if (cmd_left > 0 && op_q.size() > 0) begin
          mp = op_q.pop_front();
          chk("cmd_fid", cf.cmd_payload_function_id, cur_fid);
          chk("cmd_in0", cf.cmd_payload_inputs_0, mp[31:0]);
          chk("cmd_in1", cf.cmd_payload_inputs_1, mp[63:32]);
          exp_q.push_back('{data: mp[31:0] + mp[63:32], last: (cmd_left == 1)});
          cmd_left--;
        end
      end
      if (res_valid && res_ready) begin
        chk("res_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          er = exp_q.pop_front();
          chk("res_data", res_data, er.data);
          chk("res_last", res_last, er.last);
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- CFU responder ----------------
  logic        c_fire, r_fire, pend;
  logic [31:0] c_sum, p_sum;
  int          dcnt;

  initial begin
    cf.rsp_valid = 1'b0;
    cf.rsp_payload_outputs_0 = '0;
    pend = 1'b0;
    dcnt = 0;
    p_sum = '0;
    forever begin
      @(negedge clk);
      c_fire = cf.cmd_valid & cf.cmd_ready & ~reset;
      r_fire = cf.rsp_valid & cf.rsp_ready;
      c_sum  = cf.cmd_payload_inputs_0 + cf.cmd_payload_inputs_1;
      @(posedge clk); #1;
      if (r_fire) cf.rsp_valid = 1'b0;
      if (c_fire) begin pend = 1'b1; dcnt = rsp_delay; p_sum = c_sum; end
      if (pend) begin
        if (dcnt == 0) begin
          cf.rsp_valid = 1'b1;
          cf.rsp_payload_outputs_0 = p_sum;
          pend = 1'b0;
        end else dcnt--;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    op_valid = 1'b1; op_input_0 = a; op_input_1 = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = op_ready;
      step();
    end
    op_valid = 1'b0;
    chk("op_accept", ok, 1'b1);
    if (ok) op_q.push_back({b, a});
  endtask

  task automatic start_job(input logic [9:0] fid, input int cnt);
    bit ok = 1'b0;
    job_valid = 1'b1; job_function_id = fid; job_count = cnt[COUNT_W-1:0];
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = job_ready;
      step();
    end
    job_valid = 1'b0;
    chk("job_accept", ok, 1'b1);
    cur_fid = fid;
    cmd_left = cnt;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_job_ready"}, job_ready, 1'b1);
        chk({tag, "_res_valid"}, res_valid, 1'b1);
        chk({tag, "_res_last"}, res_last, 1'b1);
      end
      step();
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; job_valid = 1'b0; job_function_id = '0; job_count = '0;
    op_valid = 1'b1; op_input_0 = 32'hdead_beef; op_input_1 = 32'h1234_5678;
    res_ready = 1'b1; cf.cmd_ready = 1'b1;

    // reset with op_valid held high: nothing may be pushed
    step(); step();
    reset = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_op_ready", op_ready, 1'b1);
    chk("rst_rsp_ready", cf.rsp_ready, 1'b1);
    chk("rst_cmd_valid", cf.cmd_valid, 1'b0);
    chk("rst_fid", cf.cmd_payload_function_id, 10'h000);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_last", res_last, 1'b0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();

    // single 3-command job, results 3, 7, 11
    push_op(1, 2); push_op(3, 4); push_op(5, 6);
    start_job(10'h009, 3);
    @(negedge clk);
    chk("job_busy_t1", busy, 1'b1);
    chk("job_cmd_valid_t1", cf.cmd_valid, 1'b1);
    step();
    wait_done("job3");
    repeat (3) step();
    chk("job3_done_once", done_cnt, 1);

    // operand starvation and payload stability under cmd_ready=0
    start_job(10'h155, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("starve_cmd_valid", cf.cmd_valid, 1'b0); step();
    end
    cf.cmd_ready = 1'b0;
    push_op(7, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_cmd_valid", cf.cmd_valid, 1'b1);
      chk("hold_in0", cf.cmd_payload_inputs_0, 32'd7);
      chk("hold_in1", cf.cmd_payload_inputs_1, 32'd8);
      step();
    end
    cf.cmd_ready = 1'b1;
    push_op(1, 1);   // pushed in the same cycle the first command pops
    wait_done("starve");

    // result backpressure with a full FIFO
    push_op(10, 1); push_op(20, 2); push_op(30, 3); push_op(40, 4);
    @(negedge clk); chk("fifo_full_op_ready", op_ready, 1'b0); step();
    res_ready = 1'b0;
    start_job(10'h2C1, 4);
    repeat (10) step();
    @(negedge clk);
    chk("bp_res_valid", res_valid, 1'b1);
    chk("bp_res_data", res_data, 32'd11);
    chk("bp_rsp_ready", cf.rsp_ready, 1'b0);
    chk("bp_rsp_valid_held", cf.rsp_valid, 1'b1);
    step();
    res_ready = 1'b1;
    wait_done("bp");

    // count=0 job leaves the FIFO alone
    push_op(9, 1);
    start_job(10'h02A, 0);
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_cmd_valid", cf.cmd_valid, 1'b0);
    step();
    @(negedge clk);
    chk("zero_done_pulse", done, 1'b0);
    chk("zero_busy2", busy, 1'b0);
    step();
    start_job(10'h007, 1);
    wait_done("after_zero");

    // reset after the first fire, stale delayed response drained in IDLE
    push_op(2, 3); push_op(4, 4);
    rsp_delay = 3;
    start_job(10'h0F0, 2);
    begin
      bit fired = 1'b0;
      for (int i = 0; i < 50 && !fired; i++) begin
        @(negedge clk); fired = cf.cmd_valid & cf.cmd_ready; step();
      end
      chk("midrst_fire_seen", fired, 1'b1);
    end
    reset = 1'b1;
    op_q.delete(); exp_q.delete(); cmd_left = 0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_res_valid", res_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_op_ready", op_ready, 1'b1);
      step();
    end
    @(negedge clk); chk("midrst_rsp_drained", cf.rsp_valid, 1'b0); step();
    rsp_delay = 0;
    push_op(20, 22);
    start_job(10'h3C3, 1);
    wait_done("post_rst");
    repeat (3) step();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_total", done_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
